fifo_share_ctrl: RTL and testbench
==================================

Name: fifo_share_ctrl

Overview:
- Controller that shares one flag-less FIFO instance among NUM_REQ write requesters and one reader.
- Owns the FIFO's en/wea/din; tracks occupancy so the FIFO never overflows or underflows (its pointers wrap silently).
- Round-robin write arbitration, read handshake with a valid strobe aligned to the FIFO's registered dout, and a flush/drain sequence.
- Sits between PE-array result producers and the output buffer path of the accelerator.

Parameters:
- DATA_BITWIDTH, 8, word width; must match the FIFO instance.
- ADDR_BITWIDTH, 4, FIFO address width; DEPTH = 1 << ADDR_BITWIDTH.
- NUM_REQ, 4, number of write requesters (>= 2).

Ports:
- clk  in  1  clock.
- rstN  in  1  reset, asynchronous, active-low. Shared with the controlled FIFO.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_BITWIDTH  packed write data; requester i occupies bits [i*DATA_BITWIDTH +: DATA_BITWIDTH].
- req_ready  out  NUM_REQ  one-hot (or zero) write accept, combinational.
- rd_req  in  1  consumer read request.
- rd_ready  out  1  read accepted this cycle, combinational.
- rd_valid  out  1  FIFO dout holds the accepted word (one cycle after accept).
- flush  in  1  single-cycle pulse; start drain.
- busy  out  1  high while in DRAIN.
- fifo_en  out  1  FIFO read enable.
- fifo_wea  out  1  FIFO write enable.
- fifo_din  out  DATA_BITWIDTH  FIFO write data.
- count  out  ADDR_BITWIDTH+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset values: count=0, rd_valid=0, state=RUN, rr pointer=0. Combinational outputs evaluate with empty=1, so req_ready is non-zero only if some req_valid is high.
- States:
  - RUN -> DRAIN on flush.
  - DRAIN -> RUN in the cycle count reaches 0.
  - A flush while already in DRAIN is ignored.
  - A flush with count==0 spends exactly 1 cycle in DRAIN.
- Read accept (RUN): rd_ready = rd_req && !empty. fifo_en = rd_ready.
- Read accept (DRAIN): fifo_en = !empty regardless of rd_req. rd_ready=0.
- rd_valid is registered: 1 in the cycle after an accepted RUN read, 0 otherwise. Drain reads never raise rd_valid.
- Write permission: wr_ok = (state==RUN) && (!full || rd_ready). Writing when full is allowed only alongside a read, because the FIFO reads the old cell contents via its registered path.
- Arbitration:
  - Round-robin starting at rr pointer; grant = first i with req_valid[i] at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready = grant & {NUM_REQ{wr_ok}}.
  - fifo_wea = |req_ready. fifo_din = data of the granted requester.
- The rr pointer updates only on an accepted write, to (granted index + 1) mod NUM_REQ. No accept leaves the pointer unchanged.
- Count update: +1 on write only, -1 on read only (RUN or DRAIN), unchanged on both or neither. Never leaves 0..DEPTH.
- Read on empty: never issued, so there is no simultaneous read+write at empty. A write into an empty FIFO becomes readable next cycle.
- Reset mid-operation: all state is cleared immediately and asynchronously. rd_valid drops without a clock edge.

Optional Feature:
- Macro FIFO_SHARE_CTRL_HWM_EN.
- Defined: adds output hwm [ADDR_BITWIDTH:0], the high-water mark, which registers max(hwm, next count) each cycle. Reset 0; also cleared when a flush is accepted.
- Undefined: no hwm port and no hwm logic.

Decomposition:
- Package fifo_share_pkg:
  - state typedef (RUN, DRAIN).
  - DEPTH localparam function of ADDR_BITWIDTH.
  - count-width helper.
- Sub-module rr_arbiter (parameter NUM_REQ; inputs req, ptr; output one-hot grant), purely combinational. The pointer register stays in fifo_share_ctrl.

Test Plan:
- Reset, then all 4 req_valid held for 16 cycles with rd_req=0 -> grants 0,1,2,3 repeating; count reaches 16; full=1. Cycle 17 req_ready=0 and fifo_wea=0.
- Full FIFO, rd_req=1, req_valid[2]=1 -> rd_ready=1, req_ready[2]=1, count stays 16. rd_valid=1 next cycle with the oldest word on dout.
- Empty FIFO, rd_req=1 and req_valid[0]=1 with data 8'hA5 -> rd_ready=0, write accepted. Next cycle: rd_ready=1. Cycle after: rd_valid=1, dout=8'hA5.
- count=5, flush pulse -> busy for 5 cycles, fifo_en=1 each cycle, rd_valid=0, req_ready=0 throughout. Return to RUN with count=0.
- Only req_valid[3] and req_valid[1] active, pointer at 2 -> grant order 3,1,3,1. Assert rstN low mid-stream -> count=0 and rd_valid=0 immediately; after release, first grant is 1.

Source files
------------

// File: rtl/fifo_share_pkg.sv
// Shared types and sizing helpers for the shared-FIFO write/read controller.
package fifo_share_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int DEF_ADDR_BITWIDTH = 4;
  localparam int DEF_DEPTH         = 1 << DEF_ADDR_BITWIDTH;

  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int count_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one flag-less FIFO among NUM_REQ writers and one reader, with flush/drain.
// Optional high-water-mark output enabled by defining FIFO_SHARE_CTRL_HWM_EN.
module fifo_share_ctrl
  import fifo_share_pkg::*;
#(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 4,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_BITWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             rd_req,
  output logic                             rd_ready,
  output logic                             rd_valid,
  input  logic                             flush,
  output logic                             busy,
  output logic                             fifo_en,
  output logic                             fifo_wea,
  output logic [DATA_BITWIDTH-1:0]         fifo_din,
  output logic [ADDR_BITWIDTH:0]           count,
  output logic                             full,
  output logic                             empty
`ifdef FIFO_SHARE_CTRL_HWM_EN
  ,
  output logic [ADDR_BITWIDTH:0]           hwm
`endif
);

  localparam int                CW      = count_width(ADDR_BITWIDTH);
  localparam int                PW      = $clog2(NUM_REQ);
  localparam logic [CW-1:0]     DEPTH_C = CW'(fifo_depth(ADDR_BITWIDTH));
  localparam logic [PW-1:0]     LAST_C  = PW'(NUM_REQ - 1);

  state_t               state, state_d;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        gidx;
  logic [NUM_REQ-1:0]   grant;
  logic                 wr_ok;
  logic                 flush_acc;
  logic [CW-1:0]        count_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state == DRAIN);

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  // In DRAIN the FIFO is emptied unconditionally and writers are held off.
  always_comb begin
    rd_ready  = (state == RUN) && rd_req && !empty;
    fifo_en   = (state == RUN) ? rd_ready : !empty;
    wr_ok     = (state == RUN) && (!full || rd_ready);
    req_ready = grant & {NUM_REQ{wr_ok}};
    fifo_wea  = |req_ready;
    fifo_din  = req_data[gidx*DATA_BITWIDTH +: DATA_BITWIDTH];
    count_d   = count + CW'(fifo_wea) - CW'(fifo_en);
    flush_acc = (state == RUN) && flush;
    state_d   = state;
    case (state)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Registered control: state, occupancy, pointer and read-valid strobe.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= RUN;
      count    <= '0;
      rr_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      rd_valid <= rd_ready;
      if (fifo_wea) rr_ptr <= (gidx == LAST_C) ? '0 : gidx + PW'(1);
    end
  end

`ifdef FIFO_SHARE_CTRL_HWM_EN
  function automatic logic [CW-1:0] max_cnt(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)          hwm <= '0;
    else if (flush_acc) hwm <= '0;
    else                hwm <= max_cnt(hwm, count_d);
  end
`endif

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Self-checking bench for fifo_share_ctrl with a queue-based reference model.
module tb_fifo_share_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rstN;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rd_req, rd_ready, rd_valid, flush, busy;
  logic            fifo_en, fifo_wea;
  logic [DW-1:0]   fifo_din;
  logic [AW:0]     count;
  logic            full, empty;
`ifdef FIFO_SHARE_CTRL_HWM_EN
  logic [AW:0]     hwm;
`endif

  always #5 clk = ~clk;

  fifo_share_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_REQ(N)) dut (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .flush(flush), .busy(busy), .fifo_en(fifo_en), .fifo_wea(fifo_wea),
    .fifo_din(fifo_din), .count(count), .full(full), .empty(empty)
`ifdef FIFO_SHARE_CTRL_HWM_EN
    , .hwm(hwm)
`endif
  );

  // Stand-in for the flag-less FIFO: wrapping pointers, registered dout.
  logic [DW-1:0] fmem [DEPTH];
  logic [AW-1:0] fwp, frp;
  logic [DW-1:0] fdout;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fwp <= '0;
      frp <= '0;
    end else begin
      if (fifo_en)  begin fdout <= fmem[frp]; frp <= frp + 1'b1; end
      if (fifo_wea) begin fmem[fwp] <= fifo_din; fwp <= fwp + 1'b1; end
    end
  end

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            m_drain;
  int            m_ptr;
  bit            m_rdv;
  logic [DW-1:0] m_word;
  int            m_hwm;
  logic [N-1:0]  e_req_ready;
  bit            e_rd_ready, e_en, e_wea;
  logic [DW-1:0] e_din;
  int            e_gnt;
  int            vectors = 0;
  int            errors  = 0;

  task automatic model_reset();
    mq.delete();
    m_drain = 0; m_ptr = 0; m_rdv = 0; m_hwm = 0;
  endtask

  task automatic model_eval();
    int  sz;
    bit  wr_ok;
    sz         = mq.size();
    e_rd_ready = !m_drain && rd_req && (sz > 0);
    e_en       = m_drain ? (sz > 0) : e_rd_ready;
    wr_ok      = !m_drain && ((sz < DEPTH) || e_rd_ready);
    e_gnt      = -1;
    for (int k = 0; k < N; k++)
      if (e_gnt < 0 && req_valid[(m_ptr + k) % N]) e_gnt = (m_ptr + k) % N;
    e_req_ready = '0;
    e_wea       = 0;
    e_din       = '0;
    if (wr_ok && e_gnt >= 0) begin
      e_req_ready[e_gnt] = 1'b1;
      e_wea = 1;
      e_din = req_data[e_gnt*DW +: DW];
    end
  endtask

  task automatic model_commit();
    logic [DW-1:0] w;
    bit was_drain;
    was_drain = m_drain;
    m_rdv = e_rd_ready;
    if (e_en) begin
      w = mq.pop_front();
      if (e_rd_ready) m_word = w;
    end
    if (e_wea) begin
      mq.push_back(e_din);
      m_ptr = (e_gnt + 1) % N;
    end
    if (!was_drain && flush) m_hwm = 0;
    else if (mq.size() > m_hwm) m_hwm = mq.size();
    if (!was_drain && flush) m_drain = 1;
    else if (was_drain && mq.size() == 0) m_drain = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_data = '0; rd_req = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstN = 0;
    model_reset();
    #12;
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b rd_valid=%b busy=%b, want 0 1 0 0 0",
               count, empty, full, rd_valid, busy);
    end
    vectors++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_idle_ready: got %b want 0000", req_ready);
    end
    req_valid = 4'b0110;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL reset_grant: got %b want 0010", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rstN = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill(output logic [DW-1:0] first_word);
    req_valid = 4'b1111;
    for (int c = 0; c < DEPTH; c++) begin
      req_data = {$urandom, $urandom};
      #1;
      if (c == 0) first_word = req_data[7:0];
      vectors++;
      if (req_ready !== (4'b0001 << (c % 4)) || fifo_wea !== 1'b1) begin
        errors++; $display("FAIL fill_grant c=%0d: got %b wea=%b want %b", c, req_ready, fifo_wea, 4'b0001 << (c % 4));
      end
      tick();
    end
    vectors++;
    if (count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL fill_count: count=%0d full=%b want 16 1", count, full);
    end
    vectors++;
    if (req_ready !== 4'b0000 || fifo_wea !== 1'b0) begin
      errors++; $display("FAIL full_block: ready=%b wea=%b want 0000 0", req_ready, fifo_wea);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_full_rw(input logic [DW-1:0] oldest);
    rd_req = 1; req_valid = 4'b0100; req_data = {$urandom, $urandom};
    #1;
    vectors++;
    if (rd_ready !== 1'b1 || req_ready !== 4'b0100) begin
      errors++; $display("FAIL full_rw_accept: rd_ready=%b req_ready=%b want 1 0100", rd_ready, req_ready);
    end
    tick();
    rd_req = 0; req_valid = '0;
    #1;
    vectors++;
    if (count !== 5'd16 || rd_valid !== 1'b1 || fdout !== oldest) begin
      errors++; $display("FAIL full_rw_result: count=%0d rd_valid=%b dout=%h want 16 1 %h", count, rd_valid, fdout, oldest);
    end
    tick();
  endtask

  task automatic test_drain(input int n);
    int cycles;
    flush = 1;
    #1;
    tick();
    flush = 0; req_valid = 4'b1111; rd_req = 1;
    cycles = 0;
    #1;
    while (busy === 1'b1 && cycles < DEPTH + 4) begin
      vectors++;
      if (fifo_en !== (n > 0) || rd_valid !== 1'b0 || req_ready !== 4'b0000 || rd_ready !== 1'b0) begin
        errors++; $display("FAIL drain_cycle %0d: en=%b rd_valid=%b req_ready=%b rd_ready=%b", cycles, fifo_en, rd_valid, req_ready, rd_ready);
      end
      cycles++;
      tick();
    end
    vectors++;
    if (cycles != ((n > 0) ? n : 1) || count !== 5'd0) begin
      errors++; $display("FAIL drain_length: busy cycles=%0d count=%0d want %0d 0", cycles, count, (n > 0) ? n : 1);
    end
    idle_inputs();
  endtask

  task automatic test_empty_bypass();
    rd_req = 1; req_valid = 4'b0001; req_data = {24'h0, 8'hA5};
    #1;
    vectors++;
    if (rd_ready !== 1'b0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL empty_wr: rd_ready=%b req_ready=%b want 0 0001", rd_ready, req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin
      errors++; $display("FAIL empty_rd_next: rd_ready=%b want 1", rd_ready);
    end
    tick();
    rd_req = 0;
    #1;
    vectors++;
    if (rd_valid !== 1'b1 || fdout !== 8'hA5) begin
      errors++; $display("FAIL empty_dout: rd_valid=%b dout=%h want 1 a5", rd_valid, fdout);
    end
  endtask

  task automatic fill_n(input int n);
    req_valid = 4'b0001;
    for (int i = 0; i < n; i++) begin
      req_data = {$urandom, $urandom};
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_rr_sparse();
    logic [3:0] order [4];
    order[0] = 4'b1000; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0010;
    req_valid = 4'b0010; req_data = {$urandom, $urandom};
    tick();
    req_valid = 4'b1010; rd_req = 1;
    for (int c = 0; c < 4; c++) begin
      req_data = {$urandom, $urandom};
      #1;
      vectors++;
      if (req_ready !== order[c]) begin
        errors++; $display("FAIL rr_sparse c=%0d: got %b want %b", c, req_ready, order[c]);
      end
      tick();
    end
    vectors++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL rr_pre_reset_valid: got %b want 1", rd_valid);
    end
    #1;
    rstN = 0;
    model_reset();
    #1;
    vectors++;
    if (count !== 5'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: count=%0d rd_valid=%b want 0 0", count, rd_valid);
    end
    @(negedge clk);
    rstN = 1;
    rd_req = 0;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL post_reset_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    int rd_pct;
    for (int c = 0; c < 3000; c++) begin
      rd_pct    = ((c / 300) % 2) ? 80 : 25;
      req_valid = N'($urandom);
      req_data  = {$urandom, $urandom};
      rd_req    = ($urandom_range(99) < rd_pct);
      flush     = ($urandom_range(99) < 2);
      #1;
      model_eval();
      vectors++;
      if (req_ready !== e_req_ready || fifo_wea !== e_wea || (e_wea && fifo_din !== e_din)) begin
        errors++; $display("FAIL rnd_write c=%0d: ready=%b wea=%b din=%h want %b %b %h", c, req_ready, fifo_wea, fifo_din, e_req_ready, e_wea, e_din);
      end
      vectors++;
      if (rd_ready !== e_rd_ready || fifo_en !== e_en) begin
        errors++; $display("FAIL rnd_read c=%0d: rd_ready=%b en=%b want %b %b", c, rd_ready, fifo_en, e_rd_ready, e_en);
      end
      vectors++;
      if (count !== (AW+1)'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || busy !== m_drain) begin
        errors++; $display("FAIL rnd_status c=%0d: count=%0d full=%b empty=%b busy=%b want %0d %b", c, count, full, empty, busy, mq.size(), m_drain);
      end
      vectors++;
      if (rd_valid !== m_rdv || (m_rdv && fdout !== m_word)) begin
        errors++; $display("FAIL rnd_rdvalid c=%0d: rd_valid=%b dout=%h want %b %h", c, rd_valid, fdout, m_rdv, m_word);
      end
`ifdef FIFO_SHARE_CTRL_HWM_EN
      vectors++;
      if (hwm !== (AW+1)'(m_hwm)) begin
        errors++; $display("FAIL rnd_hwm c=%0d: got %0d want %0d", c, hwm, m_hwm);
      end
`endif
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    logic [DW-1:0] oldest;
    test_reset();
    test_fill(oldest);
    test_full_rw(oldest);
    test_drain(16);
    test_empty_bypass();
    fill_n(5);
    test_drain(5);
    test_drain(0);
    test_rr_sparse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
